// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer:
// buzzer indices, CPU register map, note layout and FSM states.
package melody_sequencer_pkg;

  localparam logic [7:0] BUZ_FREQ = 8'd0;
  localparam logic [7:0] BUZ_TIME = 8'd1;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_NOTE   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_STOP  = 2;
  localparam int CTRL_CLEAR = 3;

  typedef struct packed {
    logic [3:0]  code;
    logic [11:0] dur;
  } note_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WR_FREQ,
    S_WR_TIME,
    S_SETTLE,
    S_POLL,
    S_REST,
    S_NEXT,
    S_STOPPING
  } state_t;

endpackage

// File: rtl/melody_sequencer_note_ram.sv
// Note buffer: DEPTH x 16 simple dual-port,
// synchronous write, asynchronous read.
module melody_sequencer_note_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: CPU-loaded note list played
// autonomously through the buzzer register port.
import melody_sequencer_pkg::*;

module melody_sequencer #(
  parameter int DEPTH     = 16,
  parameter int MS_CYCLES = 50001
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  addrIn,
  input  logic [7:0]  addrOut,
  input  logic [3:0]  sizeDecode,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic [7:0]  buzAddrIn,
  output logic [3:0]  buzSizeDecode,
  output logic [31:0] buzDataIn,
  output logic [7:0]  buzAddrOut,
  input  logic [31:0] buzDataOut
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] MSC = 32'(MS_CYCLES);

  state_t        state;
  logic [AW:0]   count;
  logic [AW-1:0] idx;
  logic [AW-1:0] wr_ptr;
  logic          overflow;
  logic          loop_en;
  logic [31:0]   rest_cnt;
  logic          settle;
  logic [11:0]   dur;
  note_t         rd_note;
  logic [31:0]   status;

  logic ctrl_wr, note_wr;
  logic start, stop, clr;
  logic ram_we, at_end;
  logic [AW:0] last;
  logic unused;

  assign ctrl_wr = sizeDecode[0] && (addrIn[1:0] == REG_CTRL);
  assign note_wr = (&sizeDecode[1:0]) && (addrIn[1:0] == REG_NOTE);
  assign start   = ctrl_wr && dataIn[CTRL_START];
  assign stop    = ctrl_wr && dataIn[CTRL_STOP];
  assign clr     = ctrl_wr && dataIn[CTRL_CLEAR];
  assign ram_we  = note_wr && !clr && (count != FULL);
  assign last    = count - 1'b1;
  assign at_end  = ({1'b0, idx} == last);
  assign unused  = ^{addrIn[7:2], addrOut[7:2],
                     sizeDecode[3:2], dataIn[31:16]};

  melody_sequencer_note_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (dataIn[15:0]),
    .raddr (idx),
    .rdata (rd_note)
  );

  always_comb begin
    status = '0;
    status[0] = busy;
    status[1] = overflow;
    status[AW+8:8] = count;
    status[AW+16:16] = {1'b0, idx};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dataOut <= '0;
    end else begin
      unique case (1'b1)
        (addrOut[1:0] == REG_STATUS): dataOut <= status;
        default:                      dataOut <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      count         <= '0;
      wr_ptr        <= '0;
      idx           <= '0;
      overflow      <= 1'b0;
      loop_en       <= 1'b0;
      rest_cnt      <= '0;
      settle        <= 1'b0;
      dur           <= '0;
      buzAddrIn     <= '0;
      buzSizeDecode <= '0;
      buzDataIn     <= '0;
      buzAddrOut    <= '0;
    end else begin
      buzAddrOut    <= BUZ_TIME;
      buzAddrIn     <= BUZ_FREQ;
      buzSizeDecode <= '0;
      buzDataIn     <= '0;

      if (ctrl_wr) loop_en <= dataIn[CTRL_LOOP];

      if (clr) begin
        count    <= '0;
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else if (note_wr) begin
        if (count == FULL) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
      end

      // abort wins over whatever the FSM was doing
      if ((state != S_IDLE) && (stop || clr)) begin
        state         <= S_STOPPING;
        busy          <= 1'b1;
        buzAddrIn     <= BUZ_TIME;
        buzSizeDecode <= 4'hF;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !stop && (count != '0)) begin
              idx   <= '0;
              busy  <= 1'b1;
              state <= S_FETCH;
            end
          end
          S_FETCH: begin
            dur <= rd_note.dur;
            if (rd_note.dur == '0) begin
              state <= S_NEXT;
            end else if (rd_note.code == '0) begin
              rest_cnt <= {20'b0, rd_note.dur} * MSC;
              state    <= S_REST;
            end else begin
              buzAddrIn     <= BUZ_FREQ;
              buzDataIn     <= {28'b0, rd_note.code};
              buzSizeDecode <= 4'hF;
              state         <= S_WR_FREQ;
            end
          end
          S_WR_FREQ: begin
            buzAddrIn     <= BUZ_TIME;
            buzDataIn     <= {20'b0, dur};
            buzSizeDecode <= 4'hF;
            state         <= S_WR_TIME;
          end
          S_WR_TIME: begin
            settle <= 1'b0;
            state  <= S_SETTLE;
          end
          // covers buzzer write plus its read pipeline
          S_SETTLE: begin
            settle <= 1'b1;
            if (settle) state <= S_POLL;
          end
          S_POLL: begin
            if (buzDataOut == '0) state <= S_NEXT;
          end
          S_REST: begin
            if (rest_cnt == 32'd1) state <= S_NEXT;
            else rest_cnt <= rest_cnt - 32'd1;
          end
          S_NEXT: begin
            if (!at_end) begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end else if (loop_en) begin
              idx   <= '0;
              state <= S_FETCH;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_STOPPING: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end

      if (clr) idx <= '0;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a
// behavioural buzzer register model.
module tb_melody_sequencer;

  localparam int MS = 10;

  logic        clk;
  logic        rstn;
  logic [7:0]  addrIn;
  logic [7:0]  addrOut;
  logic [3:0]  sizeDecode;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        busy;
  logic [7:0]  buzAddrIn;
  logic [3:0]  buzSizeDecode;
  logic [31:0] buzDataIn;
  logic [7:0]  buzAddrOut;
  logic [31:0] buzDataOut;

  melody_sequencer #(
    .DEPTH     (16),
    .MS_CYCLES (MS)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .addrIn        (addrIn),
    .addrOut       (addrOut),
    .sizeDecode    (sizeDecode),
    .dataIn        (dataIn),
    .dataOut       (dataOut),
    .busy          (busy),
    .buzAddrIn     (buzAddrIn),
    .buzSizeDecode (buzSizeDecode),
    .buzDataIn     (buzDataIn),
    .buzAddrOut    (buzAddrOut),
    .buzDataOut    (buzDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buzzer model: FREQ/TIME regs, ms tick, registered read
  logic [31:0] bz_freq, bz_time;
  int tick;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bz_freq <= 0; bz_time <= 0; tick <= 0; buzDataOut <= 0;
    end else begin
      tick <= (tick == MS-1) ? 0 : tick + 1;
      if (buzSizeDecode == 4'hF && buzAddrIn == 8'd1)
        bz_time <= buzDataIn;
      else if (tick == MS-1 && bz_time != 0)
        bz_time <= bz_time - 1;
      if (buzSizeDecode == 4'hF && buzAddrIn == 8'd0)
        bz_freq <= buzDataIn;
      buzDataOut <= (buzAddrOut == 8'd1) ? bz_time :
                    (buzAddrOut == 8'd0) ? bz_freq : 32'd0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  la[$];
  logic [31:0] ld[$];
  int          lc[$];
  int          lbase;
  always @(posedge clk) begin
    if (rstn && buzSizeDecode == 4'hF) begin
      la.push_back(buzAddrIn);
      ld.push_back(buzDataIn);
      lc.push_back(cyc);
    end
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lsize();
    return la.size() - lbase;
  endfunction

  function automatic logic [31:0] la_at(input int i);
    return (lbase + i < la.size()) ? {24'b0, la[lbase+i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] ld_at(input int i);
    return (lbase + i < ld.size()) ? ld[lbase+i] : 32'hDEAD;
  endfunction

  function automatic int nfreq();
    int n = 0;
    for (int i = lbase; i < la.size(); i++)
      if (la[i] == 8'd0) n++;
    return n;
  endfunction

  function automatic logic [31:0] note(input int c, input int d);
    return {16'b0, 4'(c), 12'(d)};
  endfunction

  task automatic wr(input logic [7:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    @(negedge clk);
    addrIn = a; sizeDecode = be; dataIn = d;
    @(negedge clk);
    sizeDecode = 4'h0;
  endtask

  task automatic get_status(output logic [31:0] s);
    @(negedge clk);
    s = dataOut;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({name, " idle"}, {31'b0, busy}, 0);
  endtask

  task automatic wait_freq(input string name, input int n,
                           input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (nfreq() >= n) break;
    end
    check({name, " freq cnt"}, {31'b0, nfreq() >= n}, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [4:0]  cnt;
    logic        ovf;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] s;
  int t0;

  initial begin
    rstn = 1'b1;
    addrIn = 0; addrOut = 8'd2; sizeDecode = 0; dataIn = 0;
    lbase = 0;
    #2 rstn = 1'b0;
    #1;
    check("rst busy", {31'b0, busy}, 0);
    check("rst dataOut", dataOut, 0);
    check("rst buzAddrOut", {24'b0, buzAddrOut}, 0);
    check("rst buzSize", {28'b0, buzSizeDecode}, 0);
    idle_cycles(3);
    rstn = 1'b1;
    get_status(s);
    check("rst status", s, 0);

    // register-level vectors while idle
    tbl.push_back('{8'd1, 4'hF, note(1, 3),  5'd1, 1'b0, 1'b0});
    tbl.push_back('{8'd1, 4'h1, note(2, 4),  5'd1, 1'b0, 1'b0});
    tbl.push_back('{8'd1, 4'h3, note(8, 2),  5'd2, 1'b0, 1'b0});
    tbl.push_back('{8'd3, 4'hF, 32'h1,       5'd2, 1'b0, 1'b0});
    tbl.push_back('{8'd0, 4'h2, 32'h8,       5'd2, 1'b0, 1'b0});
    tbl.push_back('{8'd0, 4'h1, 32'h4,       5'd2, 1'b0, 1'b0});
    tbl.push_back('{8'd0, 4'hF, 32'h8,       5'd0, 1'b0, 1'b0});
    tbl.push_back('{8'd0, 4'hF, 32'h1,       5'd0, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      wr(tbl[i].a, tbl[i].be, tbl[i].d);
      get_status(s);
      check($sformatf("tbl%0d cnt", i), {27'b0, s[12:8]}, {27'b0, tbl[i].cnt});
      check($sformatf("tbl%0d ovf", i), {31'b0, s[1]}, {31'b0, tbl[i].ovf});
      check($sformatf("tbl%0d busy", i), {31'b0, s[0]}, {31'b0, tbl[i].bsy});
    end
    addrOut = 8'd0;
    idle_cycles(2);
    check("ctrl reads 0", dataOut, 0);
    addrOut = 8'd2;

    // 1: two tones
    wr(0, 4'hF, 32'h8);
    wr(1, 4'hF, note(1, 3));
    wr(1, 4'hF, note(8, 2));
    lbase = la.size();
    check("t1 busy pre", {31'b0, busy}, 0);
    wr(0, 4'hF, 32'h1);
    check("t1 busy post", {31'b0, busy}, 1);
    wait_idle("t1", 400);
    check("t1 nwr", lsize(), 4);
    check("t1 a0", la_at(0), 0); check("t1 d0", ld_at(0), 1);
    check("t1 a1", la_at(1), 1); check("t1 d1", ld_at(1), 3);
    check("t1 a2", la_at(2), 0); check("t1 d2", ld_at(2), 8);
    check("t1 a3", la_at(3), 1); check("t1 d3", ld_at(3), 2);
    check("t1 bztime", bz_time, 0);
    get_status(s);
    check("t1 count", {27'b0, s[12:8]}, 2);

    // 2: rest then tone, then zero-length entry
    wr(0, 4'hF, 32'h8);
    wr(1, 4'hF, note(0, 5));
    wr(1, 4'hF, note(5, 1));
    lbase = la.size();
    wr(0, 4'hF, 32'h1);
    t0 = cyc;
    wait_idle("t2", 400);
    check("t2 nwr", lsize(), 2);
    check("t2 a0", la_at(0), 0); check("t2 d0", ld_at(0), 5);
    check("t2 a1", la_at(1), 1); check("t2 d1", ld_at(1), 1);
    check("t2 rest gap",
          {31'b0, lsize() > 0 && lc[lbase] - t0 >= 50 && lc[lbase] - t0 <= 60}, 1);
    wr(0, 4'hF, 32'h8);
    wr(1, 4'hF, note(3, 0));
    lbase = la.size();
    wr(0, 4'hF, 32'h1);
    wait_idle("t2b", 50);
    check("t2b nwr", lsize(), 0);

    // 3: overflow, clear, start on empty
    wr(0, 4'hF, 32'h8);
    for (int i = 0; i < 17; i++) wr(1, 4'hF, note(1, 1));
    get_status(s);
    check("t3 count", {27'b0, s[12:8]}, 16);
    check("t3 ovf", {31'b0, s[1]}, 1);
    wr(0, 4'hF, 32'h8);
    get_status(s);
    check("t3 clr", s, 0);
    wr(0, 4'hF, 32'h1);
    idle_cycles(3);
    check("t3 empty start", {31'b0, busy}, 0);

    // 4: loop three passes, then stop mid-note
    wr(1, 4'hF, note(2, 3));
    wr(1, 4'hF, note(4, 3));
    lbase = la.size();
    wr(0, 4'hF, 32'h3);
    wait_freq("t4", 6, 2000);
    for (int i = 0; i < 3; i++) begin
      int k = 0, f = 0;
      for (int j = lbase; j < la.size(); j++) begin
        if (la[j] == 8'd0) begin
          if (f == 2*i) check($sformatf("t4 pass%0d a", i), ld[j], 2);
          if (f == 2*i+1) check($sformatf("t4 pass%0d b", i), ld[j], 4);
          f++;
        end
        k++;
      end
    end
    wait_freq("t4 7th", 7, 200);
    idle_cycles(4);
    lbase = la.size();
    wr(0, 4'h1, 32'h4);
    check("t4 stopping busy", {31'b0, busy}, 1);
    @(negedge clk);
    check("t4 stopped", {31'b0, busy}, 0);
    check("t4 nwr", lsize(), 1);
    check("t4 stop a", la_at(0), 1);
    check("t4 stop d", ld_at(0), 0);
    check("t4 bztime", bz_time, 0);

    // 5: start+stop, start while busy, reset mid-poll
    wr(0, 4'hF, 32'h8);
    wr(1, 4'hF, note(6, 2));
    wr(1, 4'hF, note(7, 3));
    lbase = la.size();
    wr(0, 4'hF, 32'h5);
    idle_cycles(5);
    check("t5 start+stop busy", {31'b0, busy}, 0);
    check("t5 start+stop nwr", lsize(), 0);
    wr(0, 4'hF, 32'h1);
    wait_freq("t5", 2, 200);
    idle_cycles(2);
    wr(0, 4'hF, 32'h1);
    get_status(s);
    check("t5 idx kept", {27'b0, s[20:16]}, 1);
    check("t5 busy kept", {31'b0, s[0]}, 1);
    idle_cycles(3);
    rstn = 1'b0;
    #1;
    check("t5 rst busy", {31'b0, busy}, 0);
    check("t5 rst bAddrIn", {24'b0, buzAddrIn}, 0);
    check("t5 rst bSize", {28'b0, buzSizeDecode}, 0);
    check("t5 rst bData", buzDataIn, 0);
    check("t5 rst bAddrOut", {24'b0, buzAddrOut}, 0);
    check("t5 rst dataOut", dataOut, 0);
    idle_cycles(2);
    rstn = 1'b1;
    get_status(s);
    check("t5 post rst", s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
